// File: rtl/pending_size_array_pkg.sv
// Shared defaults and the clamp helper for the pending-request counter bank.
// The count width is derived inside each module from its own SIZE.
package pending_size_array_pkg;

  localparam int PSA_DEF_NUM_CH = 4;
  localparam int PSA_DEF_SIZE   = 16;
  localparam int PSA_DEF_INCRW  = 2;
  localparam int PSA_DEF_DECRW  = 2;

  // Saturate a netted next count into 0..max_v without wrapping.
  function automatic int clamp_count(input int nxt, input int max_v);
    int res;
    if (nxt > max_v) begin
      res = max_v;
    end else if (nxt < 0) begin
      res = 0;
    end else begin
      res = nxt;
    end
    return res;
  endfunction

endpackage

// File: rtl/pending_size_chan.sv
// One pending-request counter: netted incr/decr, saturation, registered flags and
// sticky overflow/underflow errors. A companion checker watches the clamp events.
module pending_size_chan
  import pending_size_array_pkg::*;
#(
  parameter int SIZE      = PSA_DEF_SIZE,
  parameter int INCRW     = PSA_DEF_INCRW,
  parameter int DECRW     = PSA_DEF_DECRW,
  parameter int ALM_FULL  = SIZE - 1,
  parameter int ALM_EMPTY = 1,
  localparam int SIZEW    = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [INCRW-1:0] incr,
  input  logic [DECRW-1:0] decr,
  output logic [SIZEW-1:0] size,
  output logic             empty,
  output logic             full,
  output logic             alm_full,
  output logic             alm_empty,
  output logic             ovf_err,
  output logic             udf_err,
  output logic             empty_nxt
);

  if (SIZE < 1) begin : g_bad_size
    $error("pending_size_chan: SIZE must be at least 1");
  end
  if (INCRW > SIZEW) begin : g_bad_incrw
    $error("pending_size_chan: INCRW wider than the count");
  end
  if (DECRW > SIZEW) begin : g_bad_decrw
    $error("pending_size_chan: DECRW wider than the count");
  end
  if ((ALM_FULL < 1) || (ALM_FULL > SIZE)) begin : g_bad_alm_full
    $error("pending_size_chan: ALM_FULL outside 1..SIZE");
  end
  if ((ALM_EMPTY < 0) || (ALM_EMPTY > SIZE - 1)) begin : g_bad_alm_empty
    $error("pending_size_chan: ALM_EMPTY outside 0..SIZE-1");
  end

  logic [SIZEW-1:0] size_r;
  logic             empty_r;
  logic             full_r;
  logic             alm_full_r;
  logic             alm_empty_r;
  logic             ovf_r;
  logic             udf_r;

  int               nxt_s;
  int               cnt_s;
  logic             ovf_evt_s;
  logic             udf_evt_s;
  logic             ovf_nxt_s;
  logic             udf_nxt_s;

  // Net the request traffic in full integer width so large amounts cannot wrap,
  // then clamp; clear overrides the traffic and drops both sticky errors.
  always_comb begin
    nxt_s     = int'(size_r) + int'(incr) - int'(decr);
    ovf_evt_s = 1'b0;
    udf_evt_s = 1'b0;
    cnt_s     = 0;
    ovf_nxt_s = ovf_r;
    udf_nxt_s = udf_r;
    if (clear) begin
      cnt_s     = 0;
      ovf_nxt_s = 1'b0;
      udf_nxt_s = 1'b0;
    end else begin
      ovf_evt_s = (nxt_s > SIZE);
      udf_evt_s = (nxt_s < 0);
      cnt_s     = clamp_count(nxt_s, SIZE);
      ovf_nxt_s = ovf_r | ovf_evt_s;
      udf_nxt_s = udf_r | udf_evt_s;
    end
  end

  // Count, flags and errors all load together from the clamped next value.
  always_ff @(posedge clk) begin
    if (reset) begin
      size_r      <= {SIZEW{1'b0}};
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      alm_full_r  <= 1'b0;
      alm_empty_r <= 1'b1;
      ovf_r       <= 1'b0;
      udf_r       <= 1'b0;
    end else begin
      size_r      <= SIZEW'(cnt_s);
      empty_r     <= (cnt_s == 0);
      full_r      <= (cnt_s == SIZE);
      alm_full_r  <= (cnt_s >= ALM_FULL);
      alm_empty_r <= (cnt_s <= ALM_EMPTY);
      ovf_r       <= ovf_nxt_s;
      udf_r       <= udf_nxt_s;
    end
  end

  assign size      = size_r;
  assign empty     = empty_r;
  assign full      = full_r;
  assign alm_full  = alm_full_r;
  assign alm_empty = alm_empty_r;
  assign ovf_err   = ovf_r;
  assign udf_err   = udf_r;
  assign empty_nxt = (cnt_s == 0);

  pending_size_chan_chk #(
    .SIZE (SIZE)
  ) u_chk (
    .clk     (clk),
    .reset   (reset),
    .ovf_evt (ovf_evt_s),
    .udf_evt (udf_evt_s),
    .size    (size_r)
  );

endmodule

// Flags clamp events and guards the count range; never affects the datapath.
module pending_size_chan_chk #(
  parameter int SIZE     = 16,
  localparam int SIZEW   = $clog2(SIZE + 1)
) (
  input logic             clk,
  input logic             reset,
  input logic             ovf_evt,
  input logic             udf_evt,
  input logic [SIZEW-1:0] size
);

  ovf_clamped: cover property (@(posedge clk) disable iff (reset) ovf_evt);
  udf_clamped: cover property (@(posedge clk) disable iff (reset) udf_evt);

  size_in_range: assert property (@(posedge clk) disable iff (reset)
    int'(size) <= SIZE);
  evt_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(ovf_evt && udf_evt));

endmodule

// File: rtl/pending_size_array.sv
// Bank of independent pending-request counters plus a registered all-empty flag
// taken from the channels' next-state empties so it lines up with the empty vector.
module pending_size_array
  import pending_size_array_pkg::*;
#(
  parameter int NUM_CH    = PSA_DEF_NUM_CH,
  parameter int SIZE      = PSA_DEF_SIZE,
  parameter int INCRW     = PSA_DEF_INCRW,
  parameter int DECRW     = PSA_DEF_DECRW,
  parameter int ALM_FULL  = SIZE - 1,
  parameter int ALM_EMPTY = 1,
  localparam int SIZEW    = $clog2(SIZE + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH*INCRW-1:0] incr,
  input  logic [NUM_CH*DECRW-1:0] decr,
  output logic [NUM_CH*SIZEW-1:0] size,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       alm_full,
  output logic [NUM_CH-1:0]       alm_empty,
  output logic [NUM_CH-1:0]       ovf_err,
  output logic [NUM_CH-1:0]       udf_err,
  output logic                    all_empty
);

  logic [NUM_CH-1:0] empty_nxt_s;
  logic              all_empty_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pending_size_chan #(
      .SIZE      (SIZE),
      .INCRW     (INCRW),
      .DECRW     (DECRW),
      .ALM_FULL  (ALM_FULL),
      .ALM_EMPTY (ALM_EMPTY)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear[i]),
      .incr      (incr[i*INCRW +: INCRW]),
      .decr      (decr[i*DECRW +: DECRW]),
      .size      (size[i*SIZEW +: SIZEW]),
      .empty     (empty[i]),
      .full      (full[i]),
      .alm_full  (alm_full[i]),
      .alm_empty (alm_empty[i]),
      .ovf_err   (ovf_err[i]),
      .udf_err   (udf_err[i]),
      .empty_nxt (empty_nxt_s[i])
    );
  end

  // Aggregate empty, registered on the same edge as the per-channel flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      all_empty_r <= 1'b1;
    end else begin
      all_empty_r <= &empty_nxt_s;
    end
  end

  assign all_empty = all_empty_r;

endmodule

// File: tb/tb_pending_size_array.sv
// Directed bench for pending_size_array: a per-channel integer model checked every
// cycle, plus hand-computed literal expectations that pin both the DUT and the model.
module tb_pending_size_array;

  localparam int NCH = 4;
  localparam int SZ  = 16;
  localparam int SW  = 5;
  localparam int AF  = 15;
  localparam int AE  = 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] clear = '0;
  logic [2*NCH-1:0] incr = '0;
  logic [2*NCH-1:0] decr = '0;
  logic [NCH*SW-1:0] size;
  logic [NCH-1:0] empty, full, alm_full, alm_empty, ovf_err, udf_err;
  logic           all_empty;

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;

  int  m_size [NCH] = '{default: 0};
  bit  m_ovf  [NCH] = '{default: 1'b0};
  bit  m_udf  [NCH] = '{default: 1'b0};

  pending_size_array dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .incr      (incr),
    .decr      (decr),
    .size      (size),
    .empty     (empty),
    .full      (full),
    .alm_full  (alm_full),
    .alm_empty (alm_empty),
    .ovf_err   (ovf_err),
    .udf_err   (udf_err),
    .all_empty (all_empty)
  );

  always #5 clk = ~clk;

  function automatic int raw_next(int s, int inc, int dec);
    return s + inc - dec;
  endfunction

  function automatic int sat(int v);
    return (v > SZ) ? SZ : ((v < 0) ? 0 : v);
  endfunction

  // Model: counts as plain integers, saturated, errors sticky until reset/clear.
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset || clear[c]) begin
        m_size[c] <= 0;
        m_ovf[c]  <= 1'b0;
        m_udf[c]  <= 1'b0;
      end else begin
        m_size[c] <= sat(raw_next(m_size[c], int'(incr[c*2 +: 2]), int'(decr[c*2 +: 2])));
        m_ovf[c]  <= m_ovf[c] | (raw_next(m_size[c], int'(incr[c*2 +: 2]), int'(decr[c*2 +: 2])) > SZ);
        m_udf[c]  <= m_udf[c] | (raw_next(m_size[c], int'(incr[c*2 +: 2]), int'(decr[c*2 +: 2])) < 0);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit all_e;
      all_e = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        logic [10:0] act, exp;
        act = {size[c*SW +: SW], empty[c], full[c], alm_full[c], alm_empty[c], ovf_err[c], udf_err[c]};
        exp = {SW'(m_size[c]), m_size[c] == 0, m_size[c] == SZ, m_size[c] >= AF,
               m_size[c] <= AE, m_ovf[c], m_udf[c]};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL cyc_ch%0d t=%0t got size/e/f/af/ae/o/u=%b need %b", c, $time, act, exp);
        end
        if (m_size[c] != 0) all_e = 1'b0;
      end
      checks++;
      if (all_empty !== all_e) begin
        errors++;
        $display("FAIL cyc_all_empty t=%0t got %b need %b", $time, all_empty, all_e);
      end
    end
  end

  task automatic pin(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d need %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int ch, input int inc, input int dec);
    incr = '0;
    decr = '0;
    incr[ch*2 +: 2] = 2'(inc);
    decr[ch*2 +: 2] = 2'(dec);
  endtask

  function automatic int dsize(int ch);
    return int'(size[ch*SW +: SW]);
  endfunction

  logic [7:0] mix_inc [4] = '{8'b01_10_11_00, 8'b01_01_10_00, 8'b01_11_01_00, 8'b01_00_11_00};
  logic [7:0] mix_dec [4] = '{8'b00_00_00_11, 8'b00_01_00_11, 8'b00_00_10_10, 8'b00_10_00_01};

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) tick();
    pin("rst_size", int'(size), 0);
    pin("rst_empty", int'(empty), 15);
    pin("rst_alm_empty", int'(alm_empty), 15);
    pin("rst_all_empty", int'(all_empty), 1);
    pin("rst_err", int'({ovf_err, udf_err}), 0);

    // ch0 climbs by 3 and saturates at 16
    for (int k = 1; k <= 5; k++) begin
      drive(0, 3, 0);
      tick();
      pin($sformatf("ch0_up%0d", k), dsize(0), 3 * k);
    end
    pin("ch0_alm_full15", int'(alm_full[0]), 1);
    pin("model_ch0_15", m_size[0], 15);
    drive(0, 3, 0);
    tick();
    pin("ch0_sat_size", dsize(0), 16);
    pin("ch0_full", int'(full[0]), 1);
    pin("ch0_ovf", int'(ovf_err[0]), 1);
    drive(0, 3, 3);
    tick();
    pin("ch0_net_at_full", dsize(0), 16);

    // ch1: netted traffic, then underflow
    drive(1, 2, 0);
    tick();
    drive(1, 2, 2);
    tick();
    pin("ch1_net", dsize(1), 2);
    pin("ch1_net_alm_empty", int'(alm_empty[1]), 0);
    drive(1, 0, 3);
    tick();
    pin("ch1_udf_size", dsize(1), 0);
    pin("ch1_udf_flags", int'({empty[1], udf_err[1]}), 3);
    pin("model_ch1_udf", int'(m_udf[1]), 1);

    // ch2: build up with a sticky underflow, then clear wins over incr
    drive(2, 0, 1);
    tick();
    drive(2, 3, 0);
    tick();
    drive(2, 2, 0);
    tick();
    pin("ch2_pre_clear", dsize(2), 5);
    pin("ch2_pre_udf", int'(udf_err[2]), 1);
    drive(2, 3, 0);
    clear = 4'b0100;
    tick();
    clear = '0;
    pin("ch2_clr_size", dsize(2), 0);
    pin("ch2_clr_err", int'({ovf_err[2], udf_err[2]}), 0);
    pin("ch2_clr_alm_empty", int'(alm_empty[2]), 1);

    // mixed traffic on every channel
    for (int k = 0; k < 4; k++) begin
      incr = mix_inc[k];
      decr = mix_dec[k];
      tick();
    end
    pin("model_ch3_mix", m_size[3], 4);
    pin("mix_ch3", dsize(3), 4);

    // drain one channel at a time; ch3 goes last
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 12 && m_size[c] != 0; k++) begin
        if (c == NCH - 1) pin("drain_not_all_empty", int'(all_empty), 0);
        drive(c, 0, (m_size[c] > 3) ? 3 : m_size[c]);
        tick();
      end
      pin($sformatf("drain_ch%0d", c), dsize(c), 0);
    end
    drive(0, 0, 0);
    pin("drain_all_empty", int'(all_empty), 1);

    // reset dominates live traffic
    for (int k = 0; k < 4; k++) begin
      drive(3, 3, 0);
      tick();
    end
    pin("ch3_12", dsize(3), 12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(0, 0, 0);
    pin("rst_mid_ch3", dsize(3), 0);
    pin("rst_mid_err", int'({ovf_err, udf_err}), 0);
    pin("rst_mid_all_empty", int'(all_empty), 1);
    tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
